// File: rtl/uart_rx_if.sv
// Receive-side output bundle: received byte, per-frame outcome strobes, busy flag.
// Latency: carries registered outputs straight from uart_rx, no added delay.
// Backpressure: none; strobes last one cycle and the consumer must take them when they occur.
interface uart_rx_if;
    logic [7:0] o_dout;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_busy;

    // Driven by the receiver
    modport master (
        output o_dout,
        output o_valid,
        output o_frame_err,
        output o_parity_err,
        output o_busy
    );

    // Observed by the UART controller
    modport slave (
        input o_dout,
        input o_valid,
        input o_frame_err,
        input o_parity_err,
        input o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 (8E1 with UART_RX_PARITY_EN) frame recovery, LSB first.
// Latency: strobe one cycle after the stop-bit sample (E0+HALF+1+9*CLKS_PER_BIT, +CLKS_PER_BIT with parity).
// Backpressure: none; each byte/error is a one-cycle strobe, o_dout holds until the next good/parity frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 435
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_rx_line,
    uart_rx_if.master rx_if
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic        parity_err_q, parity_err_d;
    logic        par_mis_q, par_mis_d;
`endif

    // Next-state and output computation for the synchronizer, frame FSM and strobes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
        par_mis_d    = par_mis_q;
`endif
        // The raw pin is asynchronous; only the second stage is ever looked at.
        sync1_d = i_rx_line;
        rx_s_d  = sync1_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_mis_d = 1'b0;
`endif
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit; a short low pulse is just noise.
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = 16'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d           = 16'd0;
                    shift_d[idx_q]  = rx_s_q;
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: the parity bit makes the total count of ones even.
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = 16'd0;
                    par_mis_d = (rx_s_q != (^shift_q));
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        dout_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                        if (par_mis_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                        end
`else
                        valid_d = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is not decoded as a stream of 0x00 frames.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset puts the synchronizer at line-idle (high)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_mis_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            par_mis_q    <= par_mis_d;
`endif
        end
    end

    assign rx_if.o_dout      = dout_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = frame_err_q;
    assign rx_if.o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_parity_err = parity_err_q;
`else
    assign rx_if.o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive block: oversamples an asynchronous serial line on the system clock, recovers 8N1 frames (LSB first), and presents each received byte with a one-cycle valid strobe. It is the receive-side counterpart of the team's UART transmitter, sits behind the board RX pin and feeds the UART controller's command/byte path. Framing errors are flagged and the block re-arms only after the line returns idle.

## Interface
- CLKS_PER_BIT, 435, system clocks per bit (50 MHz / 115200 baud); legal range 4..65535
- i_clk  input  1  system clock; all state changes on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_rx_line  input  1  raw serial line, asynchronous to i_clk, idle high
- o_dout  output  8  last received byte; reset 8'h00
- o_valid  output  1  one-cycle strobe: o_dout holds a good byte; reset 0
- o_frame_err  output  1  one-cycle strobe: stop bit sampled low; reset 0
- o_parity_err  output  1  one-cycle strobe: parity mismatch; reset 0
- o_busy  output  1  high whenever state is not IDLE; reset 0

## Operation
- i_rx_line passes through a 2-flop synchronizer (both flops reset to 1); rx_s = second flop output. All decisions use rx_s only.
- HALF = (CLKS_PER_BIT-1)/2 (integer division). Counter 16 bits, bit index 3 bits.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: counter=0, idx=0; rx_s==0 -> START.
- START: count up; when counter==HALF sample rx_s: 0 -> DATA, counter=0; 1 -> IDLE (glitch rejected, no strobe).
- DATA: when counter==CLKS_PER_BIT-1 shift rx_s into shift reg at bit idx, counter=0; after idx 7 -> PARITY or STOP.
- PARITY: when counter==CLKS_PER_BIT-1 compare rx_s with even parity of the 8 data bits; store mismatch; -> STOP.
- STOP: when counter==CLKS_PER_BIT-1 sample rx_s:
  - 1: o_dout <= shift reg; o_valid=1 if no parity mismatch, else o_parity_err=1; -> IDLE.
  - 0: o_frame_err=1, o_dout unchanged; -> BREAK.
- BREAK: remain until rx_s==1, then -> IDLE. Prevents a held-low line from being decoded as repeated 0x00 frames.
- Exactly one of o_valid/o_frame_err/o_parity_err may be high in any cycle.
- o_dout is stable between strobes; changes only on the o_valid or o_parity_err cycle.
- Reset asserted mid-frame: all state and outputs return to reset values immediately; partial byte discarded, no strobe.
- Unreachable state encodings -> IDLE.

## Timing
- E0 = edge at which IDLE sees rx_s==0 (2–3 clocks after the pin falls).
- Start check at E0+HALF+1; data bit k sampled at E0+HALF+1+(k+1)·CLKS_PER_BIT.
- Stop sampled at E0+HALF+1+9·CLKS_PER_BIT (+CLKS_PER_BIT with parity); strobe is high the following cycle only.
- Returns to IDLE mid-stop-bit, so back-to-back frames with one stop bit are received without loss.
- Tolerates ±4% baud mismatch at default parameter.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1; PARITY state present; o_parity_err driven as above; stop sample shifts by CLKS_PER_BIT.
- Not defined: frame is 8N1; no PARITY state (DATA -> STOP directly); o_parity_err tied 0.

## Test plan
- CLKS_PER_BIT=16, macro off: send 0xA5 8N1 -> o_valid one cycle at E0+152, o_dout=0xA5, no error strobes.
- Back-to-back 0x00 then 0xFF, single stop bit each -> two o_valid strobes, bytes in order, nothing dropped.
- Low glitch of 5 clocks on idle line -> no strobe, o_busy returns 0 by E0+9, state IDLE.
- 0x3C with stop bit driven low, line held low 40 bit times, then high -> one o_frame_err, no o_valid, o_dout unchanged; next 0x81 received correctly.
- Macro on: 0x07 with parity 1 -> o_valid, o_dout=0x07; same byte with parity 0 -> o_parity_err only, o_dout=0x07.
- Assert i_rst_n low during DATA bit 4 -> all outputs reset immediately; after release a full 0x5A frame yields o_valid, o_dout=0x5A.
